// File: rtl/pc_fetch_sequencer.sv
// Program-counter sequencer: fetches over req/ack, delivers to decode over valid/ready.
// Optional branch statistics counters are enabled with `define BRANCH_STATS_EN.
module pc_fetch_sequencer #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int RESET_PC = 0,
  parameter int PC_INC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              instr_ready,
  input  logic              br_valid,
  input  logic              br_take,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_target
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]       br_taken_cnt,
  output logic [15:0]       br_nt_cnt
`endif
);

  localparam logic [0:0] S_FETCH   = 1'b0;
  localparam logic [0:0] S_DELIVER = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] next_pc;
  logic              accept;

  assign accept = (state_q == S_DELIVER) && instr_ready;
  assign seq_pc = pc_q + ADDR_W'(PC_INC);

  // Jump outranks a taken branch; all sums wrap modulo 2^ADDR_W.
  always_comb begin
    next_pc = seq_pc;
    if (jmp_valid) begin
      next_pc = jmp_target;
    end else if (br_valid && br_take) begin
      next_pc = seq_pc + br_offset;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_DELIVER;
        end
      end
      default: begin
        // A stray ack here is a protocol error and is deliberately ignored.
        if (accept) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= ADDR_W'(RESET_PC);
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Request is gated by reset so memory never sees a fetch during reset.
  assign imem_req    = (state_q == S_FETCH) && !rst;
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_DELIVER);

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] nt_cnt_q, nt_cnt_d;

  always_comb begin
    taken_cnt_d = taken_cnt_q;
    nt_cnt_d    = nt_cnt_q;
    if (accept && br_valid && !jmp_valid) begin
      if (br_take && (taken_cnt_q != 16'hFFFF)) begin
        taken_cnt_d = taken_cnt_q + 16'd1;
      end
      if (!br_take && (nt_cnt_q != 16'hFFFF)) begin
        nt_cnt_d = nt_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt_q <= '0;
      nt_cnt_q    <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
      nt_cnt_q    <= nt_cnt_d;
    end
  end

  assign br_taken_cnt = taken_cnt_q;
  assign br_nt_cnt    = nt_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed test-plan cases plus randomized traffic
// checked every cycle against a transaction-level model of the sequencer.
`timescale 1ns/1ps
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] pc_out;
  logic        instr_ready;
  logic        br_valid;
  logic        br_take;
  logic [15:0] br_offset;
  logic        jmp_valid;
  logic [15:0] jmp_target;
`ifdef BRANCH_STATS_EN
  logic [15:0] br_taken_cnt;
  logic [15:0] br_nt_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc_out      (pc_out),
    .instr_ready (instr_ready),
    .br_valid    (br_valid),
    .br_take     (br_take),
    .br_offset   (br_offset),
    .jmp_valid   (jmp_valid),
    .jmp_target  (jmp_target)
`ifdef BRANCH_STATS_EN
    ,
    .br_taken_cnt(br_taken_cnt),
    .br_nt_cnt   (br_nt_cnt)
`endif
  );

  // Model: "holding an instruction or not", its word, the PC, and branch tallies.
  logic        m_ready_seen;
  logic        m_have;
  logic [15:0] m_pc;
  logic [15:0] m_instr;
  int          m_taken;
  int          m_nt;

  function automatic logic [15:0] model_next_pc(input logic [15:0] pc);
    int unsigned n;
    if (jmp_valid) return jmp_target;
    n = int'(pc) + 1;
    if (br_valid && br_take) n = n + int'(br_offset);
    return n[15:0];
  endfunction

  initial m_ready_seen = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ready_seen <= 1'b1;
      m_have  <= 1'b0;
      m_pc    <= 16'h0000;
      m_instr <= 16'h0000;
      m_taken <= 0;
      m_nt    <= 0;
    end else if (!m_have) begin
      if (imem_ack) begin
        m_have  <= 1'b1;
        m_instr <= imem_rdata;
      end
    end else if (instr_ready) begin
      m_have <= 1'b0;
      m_pc   <= model_next_pc(m_pc);
      if (br_valid && !jmp_valid) begin
        if (br_take) m_taken <= (m_taken < 65535) ? m_taken + 1 : 65535;
        else         m_nt    <= (m_nt < 65535) ? m_nt + 1 : 65535;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ready_seen) begin
      chk("imem_req",    32'(imem_req),    32'(!m_have && !rst));
      chk("imem_addr",   32'(imem_addr),   32'(m_pc));
      chk("pc_out",      32'(pc_out),      32'(m_pc));
      chk("instr_valid", 32'(instr_valid), 32'(m_have));
      chk("instr",       32'(instr),       32'(m_instr));
`ifdef BRANCH_STATS_EN
      chk("br_taken_cnt", 32'(br_taken_cnt), 32'(m_taken));
      chk("br_nt_cnt",    32'(br_nt_cnt),    32'(m_nt));
`endif
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_br();
    br_valid   = 1'b0;
    br_take    = 1'b0;
    br_offset  = 16'h0000;
    jmp_valid  = 1'b0;
    jmp_target = 16'h0000;
  endtask

  // One fetch + delivery: wait ack_wait cycles, ack data, hold ready low rdy_wait cycles, accept.
  task automatic xfer(input logic [15:0] data, input logic bv, input logic bt,
                      input logic [15:0] off, input logic jv, input logic [15:0] jt,
                      input int ack_wait, input int rdy_wait);
    logic [15:0] addr0;
    addr0 = imem_addr;
    imem_ack = 1'b0;
    for (int i = 0; i < ack_wait; i++) begin
      step();
      chk("addr_stable_wait", 32'(imem_addr), 32'(addr0));
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 16'hDEAD;
    chk("deliver_valid", 32'(instr_valid), 32'h1);
    chk("deliver_instr", 32'(instr), 32'(data));
    instr_ready = 1'b0;
    for (int i = 0; i < rdy_wait; i++) begin
      step();
      chk("instr_stable", 32'(instr), 32'(data));
      chk("pc_stable", 32'(pc_out), 32'(addr0));
    end
    br_valid = bv; br_take = bt; br_offset = off; jmp_valid = jv; jmp_target = jt;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    clear_br();
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0000; instr_ready = 1'b0;
    clear_br();
    step(); step();
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_pc", 32'(pc_out), 32'h0);
    rst = 1'b0;
    step();
    chk("fetch0_addr", 32'(imem_addr), 32'h0000);

    // Zero-wait sequential fetches.
    xfer(16'h1234, 0, 0, 16'h0, 0, 16'h0, 0, 0);
    chk("seq_addr1", 32'(imem_addr), 32'h0001);
    xfer(16'h1234, 0, 0, 16'h0, 0, 16'h0, 0, 0);
    chk("seq_addr2", 32'(imem_addr), 32'h0002);

    // Branch taken / not taken at 0x0010.
    xfer(16'h1111, 0, 0, 16'h0, 1, 16'h0010, 0, 0);
    xfer(16'h2222, 1, 1, 16'h0004, 0, 16'h0, 0, 0);
    chk("br_taken_fwd", 32'(imem_addr), 32'h0015);
    xfer(16'h1111, 0, 0, 16'h0, 1, 16'h0010, 0, 0);
    xfer(16'h2222, 1, 0, 16'h0004, 0, 16'h0, 0, 0);
    chk("br_not_taken", 32'(imem_addr), 32'h0011);

    // Negative offset and wrap-around.
    xfer(16'h3333, 0, 0, 16'h0, 1, 16'h0020, 0, 0);
    xfer(16'h4444, 1, 1, 16'hFFFC, 0, 16'h0, 0, 0);
    chk("br_neg", 32'(imem_addr), 32'h001D);
    xfer(16'h5555, 0, 0, 16'h0, 1, 16'hFFFF, 0, 0);
    xfer(16'h6666, 0, 1, 16'h0004, 0, 16'h0, 0, 0);
    chk("wrap", 32'(imem_addr), 32'h0000);

    // Jump beats a taken branch.
    xfer(16'h7777, 1, 1, 16'h0004, 1, 16'h0100, 0, 0);
    chk("jmp_wins", 32'(imem_addr), 32'h0100);

    // Slow memory and stalled decode.
    xfer(16'h8888, 0, 0, 16'h0, 0, 16'h0, 3, 2);
    chk("stall_adv", 32'(imem_addr), 32'h0101);

    // Reset mid-fetch with a simultaneous ack.
    xfer(16'h9999, 0, 0, 16'h0, 1, 16'h0042, 0, 0);
    chk("at_0x42", 32'(pc_out), 32'h0042);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    step();
    rst = 1'b0; imem_ack = 1'b0;
    chk("rstmid_pc", 32'(pc_out), 32'h0000);
    chk("rstmid_valid", 32'(instr_valid), 32'h0);
    chk("rstmid_instr", 32'(instr), 32'h0000);
    step();
    chk("rstmid_refetch_req", 32'(imem_req), 32'h1);
    chk("rstmid_refetch_addr", 32'(imem_addr), 32'h0000);

`ifdef BRANCH_STATS_EN
    xfer(16'h0001, 1, 1, 16'h0001, 0, 16'h0, 0, 0);
    xfer(16'h0002, 1, 0, 16'h0001, 0, 16'h0, 0, 0);
    xfer(16'h0003, 1, 1, 16'h0001, 0, 16'h0, 0, 0);
    xfer(16'h0004, 1, 1, 16'h0001, 1, 16'h0000, 0, 0);
    chk("stat_taken", 32'(br_taken_cnt), 32'd2);
    chk("stat_nt", 32'(br_nt_cnt), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("stat_taken_clr", 32'(br_taken_cnt), 32'd0);
    chk("stat_nt_clr", 32'(br_nt_cnt), 32'd0);
`endif

    // Randomized traffic, checked each cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      imem_ack    = ($urandom_range(0, 2) == 0);
      imem_rdata  = 16'($urandom);
      instr_ready = ($urandom_range(0, 1) == 1);
      br_valid    = ($urandom_range(0, 1) == 1);
      br_take     = ($urandom_range(0, 1) == 1);
      br_offset   = 16'($urandom);
      jmp_valid   = ($urandom_range(0, 4) == 0);
      jmp_target  = 16'($urandom);
      step();
    end
    rst = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    clear_br();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
